// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_controller
// Brief    : Round sequencer for the memory matrix game. Fetches a board,
//            shows it for a fixed time, hides it, then scores one-hot tile
//            guesses until every lit tile is found (win) or the allowance
//            of misses is spent (lose).
// Revision : 1.0 - initial release
// ============================================================================
module game_controller #(
  parameter int BOARD_W     = 8,
  parameter int GUESS_W     = 4,
  parameter int MAX_GUESSES = 8,
  parameter int SHOW_CYCLES = 100000000,
  parameter int SHOW_W      = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               board_req,
  input  logic               board_valid,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [BOARD_W-1:0] guess,
  input  logic               guess_valid,
  output logic [BOARD_W-1:0] display,
  output logic [GUESS_W-1:0] guesses_left,
  output logic               hit,
  output logic               miss,
  output logic               win,
  output logic               lose,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHOW  = 3'd2,
    S_PLAY  = 3'd3,
    S_CHECK = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } state_t;

  localparam logic [GUESS_W-1:0] MAX_G     = GUESS_W'(MAX_GUESSES);
  localparam logic [SHOW_W-1:0]  SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [BOARD_W-1:0] ZERO_B    = '0;
  localparam logic [GUESS_W-1:0] ZERO_G    = '0;

  // Architectural state
  state_t             state_q;
  logic [BOARD_W-1:0] board_q;     // board latched for the current round
  logic [BOARD_W-1:0] found_q;     // correctly guessed tiles so far
  logic [BOARD_W-1:0] guess_q;     // guess captured in PLAY, scored in CHECK
  logic [BOARD_W-1:0] display_q;
  logic [GUESS_W-1:0] guesses_q;
  logic [SHOW_W-1:0]  timer_q;
  logic               board_req_q;
  logic               hit_q;
  logic               miss_q;
  logic               win_q;
  logic               lose_q;

  // Guess evaluation results, only consumed in CHECK
  logic               guess_onehot;
  logic               guess_dup;
  logic               guess_hit;
  logic [BOARD_W-1:0] found_d;
  logic [GUESS_W-1:0] guesses_d;

  // Classify the registered guess and precompute the post-guess counters
  always_comb begin
    guess_onehot = (guess_q != ZERO_B) &&
                   ((guess_q & (guess_q - BOARD_W'(1))) == ZERO_B);
    guess_dup    = (guess_q & found_q) != ZERO_B;
    guess_hit    = (guess_q & board_q) != ZERO_B;
    found_d      = found_q | guess_q;
    // Saturate at zero so a stray miss can never wrap the counter
    guesses_d    = (guesses_q == ZERO_G) ? guesses_q : (guesses_q - GUESS_W'(1));
  end

  // Round sequencer; every output is registered and set on the transition
  // into the state that owns it, so outputs line up with state_o.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      board_q     <= ZERO_B;
      found_q     <= ZERO_B;
      guess_q     <= ZERO_B;
      display_q   <= ZERO_B;
      guesses_q   <= ZERO_G;
      timer_q     <= '0;
      board_req_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      // Pulse outputs default low; a state raises them for one cycle only
      board_req_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          display_q <= ZERO_B;
          if (start) begin
            state_q     <= S_LOAD;
            board_req_q <= 1'b1;
          end
        end

        // Wait for the generator; start is deliberately not looked at here
        S_LOAD: begin
          if (board_valid) begin
            board_q   <= board_in;
            found_q   <= ZERO_B;
            guesses_q <= MAX_G;
            timer_q   <= '0;
            display_q <= board_in;
            state_q   <= S_SHOW;
          end
        end

        // Board visible; the timer runs from 0 to SHOW_CYCLES-1 inclusive
        S_SHOW: begin
          timer_q <= timer_q + SHOW_W'(1);
          if (timer_q == SHOW_LAST) begin
            if (board_q == ZERO_B) begin
              // Nothing to find: the round is trivially won
              state_q   <= S_WIN;
              win_q     <= 1'b1;
              display_q <= board_q;
            end else begin
              state_q   <= S_PLAY;
              display_q <= found_q;
            end
          end
        end

        // Board hidden; only progress shown. Guesses are not buffered elsewhere.
        S_PLAY: begin
          if (guess_valid) begin
            guess_q <= guess;
            state_q <= S_CHECK;
          end
        end

        // Score the captured guess; malformed or repeated guesses are no-ops
        S_CHECK: begin
          state_q <= S_PLAY;
          if (guess_onehot && !guess_dup) begin
            if (guess_hit) begin
              found_q <= found_d;
              hit_q   <= 1'b1;
              if (found_d == board_q) begin
                state_q   <= S_WIN;
                win_q     <= 1'b1;
                display_q <= board_q;
              end else begin
                display_q <= found_d;
              end
            end else begin
              guesses_q <= guesses_d;
              miss_q    <= 1'b1;
              if (guesses_d == ZERO_G) begin
                state_q   <= S_LOSE;
                lose_q    <= 1'b1;
                display_q <= board_q;
              end
            end
          end
        end

        // Terminal states hold the answer on display until a restart
        S_WIN, S_LOSE: begin
          if (start) begin
            state_q     <= S_LOAD;
            board_req_q <= 1'b1;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            display_q   <= ZERO_B;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          display_q <= ZERO_B;
          win_q     <= 1'b0;
          lose_q    <= 1'b0;
        end
      endcase
    end
  end

  assign board_req    = board_req_q;
  assign display      = display_q;
  assign guesses_left = guesses_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire
